rwm_frame_ctrl: RTL and testbench
=================================

Name: rwm_frame_ctrl

Overview:
Frame-level sequencer for the grayscale R/W frame memory. On each start it optionally clears the memory, then runs one WRITE pass (grayscale pixels in) and one READ pass (pixels out to downstream). It drives the memory's enable/rw/clear command lines and consumes its done/valid status. It also provides per-frame status, a read-beat length check and a per-phase timeout watchdog.

Parameters:
PIXELS, 153600, pixels per frame (480*320); expected READ beat count
TMO_W, 20, width of watchdog counter
TIMEOUT, 655360, max cycles per phase before timeout; must be > 2*PIXELS
FCNT_W, 16, width of frame counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begin a frame; honoured only in IDLE
abort  in  1  level; forces return to IDLE next cycle from any state
cfg_clear  in  1  sampled at start; 1 = run CLEAR phase before WRITE
mem_done  in  1  memory done status (combinational, last cycle of an op)
mem_valid  in  1  memory read-data-valid
mem_enable  out  1  memory enable command
mem_rw  out  1  0 = read, 1 = write
mem_clear  out  1  memory clear command
busy  out  1  high in any state except IDLE
frame_done  out  1  1-cycle pulse, frame completed without error
err_timeout  out  1  sticky; phase watchdog expired
err_len  out  1  sticky; READ beat count != PIXELS at mem_done
phase  out  3  current state encoding
frame_count  out  FCNT_W  completed-frame counter, wraps

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; latched cfg_clear 0.
- All outputs registered (Moore). Commands are held constant for a whole phase.
- States and encodings: IDLE=0, CLEAR=1, GAP1=2, WRITE=3, GAP2=4, READ=5, DONE=6, ERROR=7.
- IDLE: on start, latch cfg_clear, then go to CLEAR if latched=1, else WRITE. Clear both err flags on the transition.
- CLEAR: mem_enable=1, mem_clear=1, mem_rw=0. On mem_done go to GAP1.
- GAP1: all commands 0 for exactly 1 cycle so the memory returns to its inactive state. Then go to WRITE.
- WRITE: mem_enable=1, mem_rw=1, mem_clear=0. Pixel pacing is handled between the memory and the grayscaler; the controller only waits. On mem_done go to GAP2.
- GAP2: all commands 0 for 1 cycle, then go to READ.
- READ: mem_enable=1, mem_rw=0. Beat counter increments on each mem_valid cycle, saturating at PIXELS+1.
  - On mem_done, the total beat count includes the done cycle's beat.
  - If total != PIXELS, set err_len and go to ERROR; else go to DONE.
- DONE: 1 cycle. frame_done=1 and frame_count+1 (wrapping at 2^FCNT_W). Then go to IDLE.
- Watchdog: reset to 0 on every phase entry; increments each cycle in CLEAR/WRITE/READ.
  - When it reaches TIMEOUT-1 without mem_done, set err_timeout and go to ERROR.
  - Watchdog has priority over a mem_done in the same cycle.
- ERROR: all commands 0 and busy=1. Stays until abort; start is ignored.
- abort: highest priority in every state. Next state IDLE, commands 0, err flags retained, no frame_done, frame_count unchanged.
- start while not IDLE: ignored. start and abort together in IDLE: abort wins, stay in IDLE.
- mem_done outside CLEAR/WRITE/READ: ignored.
- Async reset mid-frame: everything returns to reset values immediately, and the memory sees mem_enable=0.
- Latency: start to mem_enable=1 is 1 cycle. mem_done to the next phase command is 2 cycles (registered state plus GAP).

Decomposition:
- Package rwm_ctrl_pkg: state encodings (3-bit), phase constants, default PIXELS/TIMEOUT, command-tuple constants (enable/rw/clear per state).
- One sub-module: rwm_phase_watchdog (counter with clear/enable/expire, parameterised TMO_W/TIMEOUT).
- FSM and beat counter stay in the top level.

Test Plan:
- Sim uses PIXELS=16, TIMEOUT=64.
- Clean frame, cfg_clear=1: start; memory model gives mem_done after 16 cycles per phase and 16 mem_valid beats in READ -> phase sequence 1,2,3,4,5,6,0; frame_done one pulse; frame_count=1; commands 0 in each GAP cycle.
- cfg_clear=0, 3 back-to-back frames -> CLEAR never entered; frame_count=3; start pulses issued while busy do not change the sequence.
- Short read: model gives 15 mem_valid beats then mem_done -> err_len=1; state ERROR (7); no frame_done; abort -> IDLE; next start clears err_len.
- Timeout: in WRITE, mem_done never asserted -> after 64 cycles err_timeout=1, state ERROR, mem_enable=0; mem_done arriving on cycle 64 is still a timeout.
- Abort mid-READ at beat 8 -> IDLE next cycle, all commands 0, frame_count unchanged, err flags 0.
- rst_n low mid-WRITE (async, off clock edge) -> all outputs 0 immediately; after release, start runs a full clean frame.

Source files
------------

// File: rtl/rwm_ctrl_pkg.sv
// rwm_ctrl_pkg: shared state encodings and per-state memory command tuples for the frame sequencer
package rwm_ctrl_pkg;

    localparam int DEF_PIXELS  = 153600;
    localparam int DEF_TIMEOUT = 655360;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_GAP1  = 3'd2,
        S_WRITE = 3'd3,
        S_GAP2  = 3'd4,
        S_READ  = 3'd5,
        S_DONE  = 3'd6,
        S_ERROR = 3'd7
    } state_e;

    typedef struct packed {
        logic enable;
        logic rw;
        logic clear;
    } cmd_t;

    localparam cmd_t CMD_OFF   = '{enable: 1'b0, rw: 1'b0, clear: 1'b0};
    localparam cmd_t CMD_CLEAR = '{enable: 1'b1, rw: 1'b0, clear: 1'b1};
    localparam cmd_t CMD_WRITE = '{enable: 1'b1, rw: 1'b1, clear: 1'b0};
    localparam cmd_t CMD_READ  = '{enable: 1'b1, rw: 1'b0, clear: 1'b0};

    function automatic cmd_t cmd_of(state_e s);
        return s == S_CLEAR ? CMD_CLEAR : s == S_WRITE ? CMD_WRITE : s == S_READ ? CMD_READ : CMD_OFF;
    endfunction

    function automatic logic is_active(state_e s);
        return s inside {S_CLEAR, S_WRITE, S_READ};
    endfunction

endpackage

// File: rtl/rwm_phase_watchdog.sv
// rwm_phase_watchdog: per-phase cycle counter that flags expiry on its last allowed cycle
module rwm_phase_watchdog #(
    parameter int TMO_W   = 20,
    parameter int TIMEOUT = 655360
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TMO_W-1:0] cnt;

    // count cycles spent in an active phase; cleared between phases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
    end

    assign expire = en && (cnt == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/rwm_frame_ctrl.sv
// rwm_frame_ctrl: clear/write/read frame sequencer for the grayscale frame memory
module rwm_frame_ctrl
    import rwm_ctrl_pkg::*;
#(
    parameter int PIXELS  = DEF_PIXELS,
    parameter int TMO_W   = 20,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int FCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_clear,
    input  logic              mem_done,
    input  logic              mem_valid,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic              mem_clear,
    output logic              busy,
    output logic              frame_done,
    output logic              err_timeout,
    output logic              err_len,
    output logic [2:0]        phase,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int BW = $clog2(PIXELS + 2);

    state_e        state, nxt;
    logic [BW-1:0] beats, beats_inc;
    logic          active, wd_exp, len_bad;

    assign active = is_active(state);
    assign phase  = state;

    rwm_phase_watchdog #(.TMO_W(TMO_W), .TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!active),
        .en     (active),
        .expire (wd_exp)
    );

    // beat total including the current cycle, saturating one past the expected count
    always_comb begin
        beats_inc = (state == S_READ && mem_valid && beats != BW'(PIXELS + 1)) ? beats + 1'b1 : beats;
        len_bad   = state == S_READ && mem_done && !wd_exp && beats_inc != BW'(PIXELS);
    end

    // next phase: abort beats everything, watchdog beats mem_done
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = start ? (cfg_clear ? S_CLEAR : S_WRITE) : S_IDLE;
            S_CLEAR: nxt = wd_exp ? S_ERROR : mem_done ? S_GAP1 : S_CLEAR;
            S_GAP1:  nxt = S_WRITE;
            S_WRITE: nxt = wd_exp ? S_ERROR : mem_done ? S_GAP2 : S_WRITE;
            S_GAP2:  nxt = S_READ;
            S_READ:  nxt = wd_exp ? S_ERROR : mem_done ? (len_bad ? S_ERROR : S_DONE) : S_READ;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_ERROR;
        endcase
        if (abort) nxt = S_IDLE;
    end

    // state plus every output registered from the next state so commands hold for a whole phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                           <= S_IDLE;
            {mem_enable, mem_rw, mem_clear} <= '0;
            busy                            <= 1'b0;
            frame_done                      <= 1'b0;
            err_timeout                     <= 1'b0;
            err_len                         <= 1'b0;
            frame_count                     <= '0;
            beats                           <= '0;
        end else begin
            state                           <= nxt;
            {mem_enable, mem_rw, mem_clear} <= cmd_of(nxt);
            busy                            <= nxt != S_IDLE;
            frame_done                      <= nxt == S_DONE;
            beats                           <= state == S_READ ? beats_inc : '0;
            if (nxt == S_DONE) frame_count <= frame_count + 1'b1;
            if (state == S_IDLE && start && !abort) begin
                err_timeout <= 1'b0;
                err_len     <= 1'b0;
            end else if (!abort) begin
                if (wd_exp)  err_timeout <= 1'b1;
                if (len_bad) err_len     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rwm_frame_ctrl.sv
// tb_rwm_frame_ctrl: randomized scoreboard bench for the frame sequencer with a behavioural memory model
module tb_rwm_frame_ctrl;

    localparam int PIXELS  = 16;
    localparam int TIMEOUT = 64;
    localparam int TMO_W   = 20;
    localparam int FCNT_W  = 16;

    logic clk = 0, rst_n = 0, start = 0, abort = 0, cfg_clear = 0, mem_done = 0, mem_valid = 0;
    logic mem_enable, mem_rw, mem_clear, busy, frame_done, err_timeout, err_len;
    logic [2:0] phase;
    logic [FCNT_W-1:0] frame_count;

    always #5 clk = ~clk;

    rwm_frame_ctrl #(.PIXELS(PIXELS), .TMO_W(TMO_W), .TIMEOUT(TIMEOUT), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_clear(cfg_clear),
        .mem_done(mem_done), .mem_valid(mem_valid), .mem_enable(mem_enable), .mem_rw(mem_rw),
        .mem_clear(mem_clear), .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout),
        .err_len(err_len), .phase(phase), .frame_count(frame_count)
    );

    typedef struct {
        logic [31:0]       trace;
        bit                tmo;
        bit                len;
        bit                done;
        logic [FCNT_W-1:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int vectors = 0, miscompares = 0;
    int dc = 16, dw = 16, dr = 16, nb = 16;
    int frames_ended = 0;
    logic [2:0] end_phase = 0;
    logic [FCNT_W-1:0] model_fcnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic bit bad(int d);
        return d == 0 || d >= TIMEOUT;
    endfunction

    // expected phase trace (one nibble per phase visited) and end status of one frame
    function automatic exp_t model(bit clr, int c, int w, int r, int b, int mode);
        exp_t e;
        e.trace = 0; e.tmo = 0; e.len = 0; e.done = 0; e.fcnt = model_fcnt;
        if (clr) begin
            e.trace = 1;
            if (bad(c)) begin e.trace = (e.trace << 4) | 7; e.tmo = 1; return e; end
            e.trace = (e.trace << 4) | 2;
        end
        e.trace = (e.trace << 4) | 3;
        if (mode == 2) begin e.trace = e.trace << 4; model_fcnt = 0; e.fcnt = 0; return e; end
        if (bad(w)) begin e.trace = (e.trace << 4) | 7; e.tmo = 1; return e; end
        e.trace = (e.trace << 8) | 32'h45;
        if (mode == 1) begin e.trace = e.trace << 4; return e; end
        if (bad(r)) begin e.trace = (e.trace << 4) | 7; e.tmo = 1; return e; end
        if (b != PIXELS) begin e.trace = (e.trace << 4) | 7; e.len = 1; return e; end
        e.trace = (e.trace << 8) | 32'h60;
        e.done = 1;
        model_fcnt = model_fcnt + 1'b1;
        e.fcnt = model_fcnt;
        return e;
    endfunction

    // memory: done on cycle d of the enabled op, read beats on the last nb cycles ending with done
    initial begin
        int cyc = 0, d;
        forever begin
            @(posedge clk); #1;
            if (mem_enable !== 1'b1) begin
                cyc = 0; mem_done = 0; mem_valid = 0;
            end else begin
                cyc++;
                d = mem_clear ? dc : mem_rw ? dw : dr;
                mem_done  = d != 0 && cyc == d;
                mem_valid = !mem_rw && !mem_clear && cyc > d - nb && cyc <= d;
            end
        end
    end

    // monitor: per-cycle command checks and per-frame scoreboard compare
    initial begin
        logic [2:0] prev = 0;
        bit in_frame = 0;
        logic [31:0] tr = 0;
        int ndone = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            chk("cmd_busy", {mem_enable, mem_rw, mem_clear, busy},
                {phase inside {3'd1, 3'd3, 3'd5}, phase == 3'd3, phase == 3'd1, phase != 3'd0});
            if (phase !== prev && !in_frame && prev == 0) begin
                in_frame = 1; tr = 32'(phase); ndone = 0;
            end else if (phase !== prev && in_frame) tr = (tr << 4) | 32'(phase);
            if (frame_done) ndone++;
            if (phase !== prev && in_frame && (phase == 0 || phase == 7)) begin
                in_frame = 0;
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL frame_end: got trace %0h, expected no frame", tr);
                end else begin
                    e = exp_q.pop_front();
                    chk("trace", tr, e.trace);
                    chk("err_timeout", 32'(err_timeout), 32'(e.tmo));
                    chk("err_len", 32'(err_len), 32'(e.len));
                    chk("frame_count", 32'(frame_count), 32'(e.fcnt));
                    chk("frame_done_pulses", ndone, 32'(e.done));
                end
                end_phase = phase;
                frames_ended++;
            end
            prev = phase;
        end
    end

    // mode: 0 plain, 1 abort at 8th read beat, 2 async reset mid-WRITE, 3 stray starts while busy
    task automatic run_frame(bit clr, int c, int w, int r, int b, int mode);
        exp_t e;
        int n0, k = 0, nbeat = 0;
        dc = c; dw = w; dr = r; nb = b;
        e = model(clr, c, w, r, b, mode);
        exp_q.push_back(e);
        last_exp = e;
        n0 = frames_ended;
        @(negedge clk); #1;
        cfg_clear = clr; start = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            start = 0; abort = 0; cfg_clear = 1'($urandom_range(0, 1));
            if (frames_ended != n0) break;
            if (mode == 3 && phase != 0) start = ($urandom_range(0, 3) == 0);
            if (mode == 1 && phase == 5 && mem_valid) begin
                nbeat++;
                if (nbeat == 8) abort = 1;
            end
            if (mode == 2 && phase == 3) begin
                k++;
                if (k == 5) begin
                    rst_n = 0; #1;
                    chk("async_reset_outputs", {mem_enable, mem_rw, mem_clear, busy, frame_done,
                        err_timeout, err_len, phase, frame_count}, 0);
                    @(negedge clk); #1 rst_n = 1;
                end
            end
        end
        if (frames_ended == n0) begin
            vectors++; miscompares++;
            $display("FAIL frame_wait: no frame end within 1000 cycles, phase %0d", phase);
            exp_q.delete();
            abort = 1; @(negedge clk); #1 abort = 0;
        end else if (end_phase == 7) begin
            start = 1; @(negedge clk); #1 start = 0;
            @(negedge clk); #1;
            chk("error_ignores_start", phase, 7);
            chk("error_busy", busy, 1);
            abort = 1; @(negedge clk); #1 abort = 0;
            chk("abort_from_error", phase, 0);
            chk("err_flags_kept", {err_timeout, err_len}, {last_exp.tmo, last_exp.len});
        end
    endtask

    function automatic int pick_dur();
        int v = $urandom_range(0, 9);
        return v == 0 ? 0 : v == 1 ? 64 : v == 2 ? 63 : $urandom_range(1, 40);
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_phase", phase, 0);
        chk("reset_cmds", {mem_enable, mem_rw, mem_clear}, 0);
        chk("reset_status", {busy, frame_done, err_timeout, err_len}, 0);
        chk("reset_fcount", frame_count, 0);
        #1 rst_n = 1;
        @(negedge clk); #1 start = 1; abort = 1;
        @(negedge clk); #1 start = 0; abort = 0;
        @(negedge clk); #1;
        chk("start_abort_idle", {phase, busy}, 0);
        run_frame(1, 16, 16, 16, 16, 0);
        chk("fcount_after_first", frame_count, 1);
        repeat (3) run_frame(0, 16, 16, 16, 16, 3);
        run_frame(0, 16, 16, 16, 15, 0);
        run_frame(0, 16, 16, 16, 16, 0);
        run_frame(0, 16, 0, 16, 16, 0);
        run_frame(1, 16, 64, 16, 16, 0);
        run_frame(0, 16, 63, 16, 16, 0);
        run_frame(0, 16, 16, 20, 18, 0);
        run_frame(0, 16, 16, 20, 17, 0);
        run_frame(0, 16, 16, 20, 16, 1);
        run_frame(0, 16, 50, 16, 16, 2);
        run_frame(1, 16, 16, 16, 16, 0);
        for (int i = 0; i < 25; i++) begin
            int r = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(18, 40);
            int b = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 18) : PIXELS;
            run_frame(1'($urandom_range(0, 1)), pick_dur(), pick_dur(), r, b, $urandom_range(0, 1) * 3);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "time limit");
    end

endmodule
